// File: rtl/vending_pkg.sv
// Shared vending-machine types: coin width and the dispenser state encoding.
package vending_pkg;

    localparam int COIN_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PULSE,
        S_WAIT_ACK,
        S_GAP,
        S_DONE,
        S_FAULT
    } dispenser_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; expired is high once the count reaches zero.
module cycle_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= value;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// Pays out latched change one coin at a time, pulsing the ejector and
// waiting for the coin-drop sensor after each pulse.
module change_dispenser
    import vending_pkg::*;
#(
    parameter int WIDTH        = COIN_W,
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 4,
    parameter int ACK_TIMEOUT  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] change,
    input  logic             coin_ack,
    input  logic             clear_fault,
    output logic             eject,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [WIDTH-1:0] remaining,
    output logic [WIDTH-1:0] coins_paid
);

    localparam int TW =
        $clog2(max3(PULSE_CYCLES, GAP_CYCLES, ACK_TIMEOUT)) + 1;

    dispenser_state_t state_q, state_d;

    logic             ack_q;
    logic             ack_pend_q;
    logic             ack_rise;
    logic             ack_hit;
    logic             tmr_load;
    logic [TW-1:0]    tmr_val;
    logic             tmr_exp;
    logic             eject_q, busy_q, done_q, fault_q;
    logic [WIDTH-1:0] remaining_q, coins_paid_q;

    assign ack_rise = coin_ack & ~ack_q;

    always_comb begin
        state_d = state_q;
        ack_hit = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start)
                    state_d = (change != '0) ? S_PULSE : S_DONE;
            end
            S_PULSE: begin
                if (tmr_exp)
                    state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                ack_hit = ack_pend_q | ack_rise;
                if (ack_hit)
                    state_d = (remaining_q <= WIDTH'(1)) ? S_DONE : S_GAP;
                else if (tmr_exp)
                    state_d = S_FAULT;
            end
            S_GAP: begin
                if (tmr_exp)
                    state_d = S_PULSE;
            end
            S_DONE:  state_d = S_IDLE;
            S_FAULT: begin
                if (clear_fault)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The shared timer restarts on every state entry with that state's length.
    assign tmr_load = (state_d != state_q);

    always_comb begin
        tmr_val = '0;
        unique case (state_d)
            S_PULSE:    tmr_val = TW'(PULSE_CYCLES - 1);
            S_WAIT_ACK: tmr_val = TW'(ACK_TIMEOUT - 1);
            S_GAP:      tmr_val = TW'(GAP_CYCLES - 1);
            default:    tmr_val = '0;
        endcase
    end

    cycle_timer #(
        .W(TW)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tmr_load),
        .value   (tmr_val),
        .expired (tmr_exp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ack_q        <= 1'b0;
            ack_pend_q   <= 1'b0;
            eject_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
            remaining_q  <= '0;
            coins_paid_q <= '0;
        end else begin
            state_q    <= state_d;
            ack_q      <= coin_ack;
            ack_pend_q <= (state_q == S_PULSE) & (ack_pend_q | ack_rise);
            eject_q    <= (state_d == S_PULSE);
            busy_q     <= (state_d != S_IDLE);
            done_q     <= (state_d == S_DONE);
            fault_q    <= (state_d == S_FAULT);
            if (state_q == S_IDLE && start) begin
                remaining_q  <= change;
                coins_paid_q <= '0;
            end else if (ack_hit && remaining_q != '0) begin
                remaining_q  <= remaining_q - WIDTH'(1);
                coins_paid_q <= coins_paid_q + WIDTH'(1);
            end
        end
    end

    assign eject      = eject_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign fault      = fault_q;
    assign remaining  = remaining_q;
    assign coins_paid = coins_paid_q;

endmodule
